// File: rtl/tx_pkt_arbiter.sv
// tx_pkt_arbiter: round-robin packet arbiter muxing NUM_SRC word sources onto one tx path.
module tx_pkt_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int NUM_SRC       = 4,
  parameter int SRC_IDX_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*CTRL_WIDTH-1:0] src_ctrl,
  input  logic [NUM_SRC-1:0]            src_wr,
  input  logic [NUM_SRC-1:0]            src_eop,
  output logic [NUM_SRC-1:0]            src_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  input  logic                          arb_en,
  output logic [SRC_IDX_WIDTH-1:0]      grant_idx,
  output logic                          busy,
  output logic [31:0]                   pkts_sent
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t                   state_q, state_d;
  logic [SRC_IDX_WIDTH-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]    out_ctrl_q, out_ctrl_d;
  logic                     out_wr_q, out_wr_d;
  logic [31:0]              pkts_q, pkts_d;
  logic                     found, acc, eop, new_grant;
  // Descending scan so the requester closest after last_q is the one that sticks.
  always_comb begin
    pick  = grant_q;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SRC_IDX_WIDTH'((int'(last_q) + k) % NUM_SRC);
      if (src_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    acc        = state_q == XFER && out_rdy && src_wr[grant_q];
    eop        = acc && src_eop[grant_q];
    new_grant  = state_q == IDLE && arb_en && found;
    state_d    = state_q == IDLE ? (new_grant ? XFER : IDLE) : (eop ? IDLE : XFER);
    grant_d    = new_grant ? pick : grant_q;
    last_d     = eop ? grant_q : last_q;
    pkts_d     = pkts_q + 32'(eop);
    out_wr_d   = acc;
    out_data_d = acc ? src_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : out_data_q;
    out_ctrl_d = acc ? src_ctrl[grant_q*CTRL_WIDTH +: CTRL_WIDTH] : out_ctrl_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= SRC_IDX_WIDTH'(NUM_SRC-1);
      pkts_q     <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      pkts_q     <= pkts_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
    end
  end
  assign src_rdy   = (state_q == XFER && out_rdy) ? NUM_SRC'(1) << grant_q : '0;
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_wr    = out_wr_q;
  assign grant_idx = grant_q;
  assign busy      = state_q == XFER;
  assign pkts_sent = pkts_q;
endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// tb_tx_pkt_arbiter: directed bench with an output-word scoreboard for tx_pkt_arbiter.
module tb_tx_pkt_arbiter;
  logic         clk = 0;
  logic         reset;
  logic [3:0]   src_req, src_wr, src_eop, src_rdy;
  logic [255:0] src_data;
  logic [31:0]  src_ctrl;
  logic [63:0]  out_data, last_data;
  logic [7:0]   out_ctrl;
  logic         out_wr, out_rdy, arb_en, busy;
  logic [1:0]   grant_idx;
  logic [31:0]  pkts_sent;
  logic [71:0]  q[$];
  int           vectors = 0, errs = 0, n_pkts = 0;
  tx_pkt_arbiter dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data), .src_ctrl(src_ctrl),
    .src_wr(src_wr), .src_eop(src_eop), .src_rdy(src_rdy), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy), .arb_en(arb_en),
    .grant_idx(grant_idx), .busy(busy), .pkts_sent(pkts_sent)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One clock; every cycle the output port is checked against the scoreboard head.
  task automatic tick();
    logic [71:0] e;
    @(posedge clk);
    #1;
    chk("out_wr", 64'(out_wr), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_data", out_data, e[63:0]);
      chk("out_ctrl", 64'(out_ctrl), 64'(e[71:64]));
    end
  endtask
  task automatic send_word(input int g, input logic [63:0] d, input logic e);
    logic [7:0] c;
    c = d[7:0] ^ 8'hA5;
    src_wr = '0;
    src_eop = '0;
    src_wr[g] = 1'b1;
    src_eop[g] = e;
    src_data[g*64 +: 64] = d;
    src_ctrl[g*8 +: 8] = c;
    #1;
    chk("src_rdy", 64'(src_rdy), 64'(4'b0001 << g));
    q.push_back({c, d});
    last_data = d;
    tick();
    src_wr = '0;
    src_eop = '0;
  endtask
  task automatic pkt(input int g, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) send_word(g, base + 64'(i), i == n - 1);
    n_pkts++;
    chk("busy_after_eop", 64'(busy), 64'd0);
    chk("pkts_sent", 64'(pkts_sent), 64'(n_pkts));
  endtask
  task automatic grant(input int g);
    tick();
    chk("busy_grant", 64'(busy), 64'd1);
    chk("grant_idx", 64'(grant_idx), 64'(g));
  endtask
  initial begin
    reset = 1; src_req = '0; src_wr = '0; src_eop = '0; src_data = '0; src_ctrl = '0;
    out_rdy = 1; arb_en = 1; last_data = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_pkts", 64'(pkts_sent), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_src_rdy", 64'(src_rdy), 64'd0);
    reset = 0;
    // single source, request dropped mid-packet
    src_req = 4'b0100;
    grant(2);
    src_req = 4'b0000;
    pkt(2, 3, 64'h2000_0000_0000_0010);
    tick();
    chk("hold_out_data", out_data, last_data);
    chk("idle_busy", 64'(busy), 64'd0);
    // round robin from a fresh reset
    reset = 1; tick(); reset = 0; n_pkts = 0;
    src_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      grant(i % 4);
      pkt(i % 4, 2, 64'h3000_0000_0000_0000 + 64'(i * 16));
    end
    // backpressure mid-packet
    grant(1);
    send_word(1, 64'h4000_0000_0000_0001, 1'b0);
    out_rdy = 0;
    src_wr = 4'b0010;
    src_data[64 +: 64] = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_src_rdy", 64'(src_rdy), 64'd0);
      tick();
      chk("bp_busy", 64'(busy), 64'd1);
    end
    out_rdy = 1;
    send_word(1, 64'h4000_0000_0000_0002, 1'b0);
    pkt(1, 1, 64'h4000_0000_0000_0003);
    // non-granted write ignored, arb_en dropped mid-packet
    grant(2);
    src_wr = 4'b0001;
    src_data[63:0] = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("ng_src_rdy", 64'(src_rdy), 64'b0100);
    tick();
    src_wr = '0;
    send_word(2, 64'h5000_0000_0000_0000, 1'b0);
    arb_en = 0;
    send_word(2, 64'h5000_0000_0000_0001, 1'b0);
    pkt(2, 2, 64'h5000_0000_0000_0002);
    src_req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arb_off_busy", 64'(busy), 64'd0);
      chk("arb_off_grant", 64'(grant_idx), 64'd2);
    end
    arb_en = 1;
    grant(0);
    pkt(0, 2, 64'h6000_0000_0000_0000);
    // reset mid-packet abandons it
    grant(1);
    send_word(1, 64'h7000_0000_0000_0000, 1'b0);
    src_wr = 4'b0010;
    src_data[64 +: 64] = 64'h7000_0000_0000_0001;
    reset = 1;
    tick();
    src_wr = '0;
    n_pkts = 0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pkts", 64'(pkts_sent), 64'd0);
    chk("mid_rst_src_rdy", 64'(src_rdy), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    reset = 0;
    src_req = 4'b1000;
    grant(3);
    pkt(3, 2, 64'h8000_0000_0000_0000);
    reset = 1; tick(); reset = 0; n_pkts = 0;
    src_req = 4'b1001;
    grant(0);
    pkt(0, 2, 64'h9000_0000_0000_0000);
    // counter wrap
    force dut.pkts_q = 32'hFFFF_FFFF;
    tick(); tick();
    release dut.pkts_q;
    #1;
    chk("wrap_pre", 64'(pkts_sent), 64'hFFFF_FFFF);
    grant(3);
    n_pkts = -1;
    pkt(3, 1, 64'hA000_0000_0000_0000);
    chk("wrap_post", 64'(pkts_sent), 64'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
